// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Double-buffered digit data is swapped in only at frame boundaries; all outputs registered.
module seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 4,
    parameter int BLANK  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     mask_in,
    output logic [3:0]            nib_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = $clog2(DIGITS);
    localparam bit HAS_GAP = (BLANK > 0);

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    logic [DIGITS-1:0][3:0]   act_data_q, act_data_d;
    logic [DIGITS-1:0]        act_mask_q, act_mask_d;
    logic [DIGITS-1:0][3:0]   pend_data_q, pend_data_d;
    logic [DIGITS-1:0]        pend_mask_q, pend_mask_d;
    logic                     pend_valid_q, pend_valid_d;

    logic [3:0]               nib_d;
    logic [DIGITS-1:0]        sel_d;
    logic                     frame_done_d;

    // swap: active buffer may be refreshed on this edge (frame boundary or IDLE entry)
    logic                     swap;
    logic                     boundary;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        swap     = 1'b0;
        boundary = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                    swap    = 1'b1;
                end
            end

            SHOW: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (HAS_GAP) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        swap     = 1'b1;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            GAP: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != BLANK_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        swap     = 1'b1;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Buffer update: a load on a swap edge bypasses pending and goes straight to active.
    always_comb begin
        act_data_d   = act_data_q;
        act_mask_d   = act_mask_q;
        pend_data_d  = pend_data_q;
        pend_mask_d  = pend_mask_q;
        pend_valid_d = pend_valid_q;

        if (swap) begin
            if (load) begin
                act_data_d   = data_in;
                act_mask_d   = mask_in;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                act_data_d   = pend_data_q;
                act_mask_d   = pend_mask_q;
                pend_valid_d = 1'b0;
            end
        end else if (load) begin
            pend_data_d  = data_in;
            pend_mask_d  = mask_in;
            pend_valid_d = 1'b1;
        end
    end

    // Outputs are computed from the next state so the registered copies line up with it.
    always_comb begin
        nib_d        = 4'h0;
        sel_d        = '0;
        frame_done_d = boundary;

        unique case (state_d)
            SHOW: begin
                nib_d = act_data_d[idx_d];
                if (!act_mask_d[idx_d]) begin
                    sel_d = DIGITS'(1) << idx_d;
                end
            end
            GAP: begin
                nib_d = nib_out;
            end
            default: begin
                nib_d = 4'h0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            act_data_q   <= '0;
            act_mask_q   <= '0;
            pend_data_q  <= '0;
            pend_mask_q  <= '0;
            pend_valid_q <= 1'b0;
            nib_out      <= 4'h0;
            dig_sel      <= '0;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            act_data_q   <= act_data_d;
            act_mask_q   <= act_mask_d;
            pend_data_q  <= pend_data_d;
            pend_mask_q  <= pend_mask_d;
            pend_valid_q <= pend_valid_d;
            nib_out      <= nib_d;
            dig_sel      <= sel_d;
            frame_done   <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: DIGITS=4, DIV=4 with BLANK=1 (dut_a) and BLANK=0 (dut_b).
// Expected outputs come from the frame position: slot = pos / period, lit while phase < DIV.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, enable, load;
    logic [15:0] data_in;
    logic [3:0]  mask_in;
    logic [3:0]  nib_a, sel_a;
    logic        fd_a;

    logic        rst_b_n, enable_b, load_b;
    logic [15:0] data_b;
    logic [3:0]  mask_b;
    logic [3:0]  nib_b, sel_b;
    logic        fd_b;

    int n_tests = 0;
    int n_fail  = 0;
    int pos     = 0;
    bit first   = 1'b1;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(4), .DIV(4), .BLANK(1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .mask_in    (mask_in),
        .nib_out    (nib_a),
        .dig_sel    (sel_a),
        .frame_done (fd_a)
    );

    seg_scan_ctrl #(.DIGITS(4), .DIV(4), .BLANK(0)) dut_b (
        .clk        (clk),
        .rst_n      (rst_b_n),
        .enable     (enable_b),
        .load       (load_b),
        .data_in    (data_b),
        .mask_in    (mask_b),
        .nib_out    (nib_b),
        .dig_sel    (sel_b),
        .frame_done (fd_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dark(input string tag);
        chk({tag, "_sel"}, {12'h0, sel_a}, 16'h0);
        chk({tag, "_nib"}, {12'h0, nib_a}, 16'h0);
        chk({tag, "_fd"},  {15'h0, fd_a},  16'h0);
    endtask

    // Check the current cycle against the position model, no clock advance.
    task automatic exp_now(input string tag, input logic [15:0] val, input logic [3:0] msk,
                           input bit on_b);
        int         per;
        int         slot;
        int         ph;
        logic [3:0] e_sel;
        logic [3:0] e_nib;
        logic       e_fd;
        per   = on_b ? 4 : 5;
        slot  = pos / per;
        ph    = pos % per;
        e_sel = (ph < 4 && !msk[slot]) ? 4'(1 << slot) : 4'h0;
        e_nib = val[4*slot +: 4];
        e_fd  = (pos == 0) && !first;
        if (on_b) begin
            chk({tag, "_sel"}, {12'h0, sel_b}, {12'h0, e_sel});
            chk({tag, "_nib"}, {12'h0, nib_b}, {12'h0, e_nib});
            chk({tag, "_fd"},  {15'h0, fd_b},  {15'h0, e_fd});
        end else begin
            chk({tag, "_sel"}, {12'h0, sel_a}, {12'h0, e_sel});
            chk({tag, "_nib"}, {12'h0, nib_a}, {12'h0, e_nib});
            chk({tag, "_fd"},  {15'h0, fd_a},  {15'h0, e_fd});
        end
    endtask

    task automatic cyc(input string tag, input logic [15:0] val, input logic [3:0] msk,
                       input bit on_b);
        int flen;
        flen = on_b ? 16 : 20;
        exp_now(tag, val, msk, on_b);
        tick();
        pos++;
        if (pos == flen) begin
            pos   = 0;
            first = 1'b0;
        end
    endtask

    task automatic run(input string tag, input int n, input logic [15:0] val,
                       input logic [3:0] msk, input bit on_b);
        for (int i = 0; i < n; i++) cyc(tag, val, msk, on_b);
    endtask

    initial begin
        rst_n    = 1'b0; enable   = 1'b0; load   = 1'b0; data_in = '0; mask_in = '0;
        rst_b_n  = 1'b0; enable_b = 1'b0; load_b = 1'b0; data_b  = '0; mask_b  = '0;
        tick();
        tick();
        dark("reset");
        rst_n = 1'b1;
        tick();
        dark("idle");

        // Scenario 1: load in IDLE, then enable; two full frames of 1,2,3,4.
        data_in = 16'h4321; mask_in = 4'h0; load = 1'b1;
        tick();
        load = 1'b0;
        dark("idle_load");
        enable = 1'b1;
        tick();
        pos = 0; first = 1'b1;
        run("s1", 40, 16'h4321, 4'h0, 1'b0);

        // Scenario 2: mid-frame load waits for the next frame.
        run("s2_old", 7, 16'h4321, 4'h0, 1'b0);
        data_in = 16'h8765; load = 1'b1;
        cyc("s2_ld", 16'h4321, 4'h0, 1'b0);
        load = 1'b0;
        run("s2_rest", 12, 16'h4321, 4'h0, 1'b0);
        run("s2_new", 20, 16'h8765, 4'h0, 1'b0);

        // Scenario 3a: load on the boundary edge shows on digit 0 of the next frame.
        run("s3_pre", 19, 16'h8765, 4'h0, 1'b0);
        data_in = 16'hA9CB; load = 1'b1;
        cyc("s3_bld", 16'h8765, 4'h0, 1'b0);
        load = 1'b0;
        run("s3_bnd", 3, 16'hA9CB, 4'h0, 1'b0);

        // Scenario 3b: two loads in one frame, only the second is shown.
        data_in = 16'h2468; load = 1'b1;
        cyc("s3_l1", 16'hA9CB, 4'h0, 1'b0);
        load = 1'b0;
        run("s3_mid", 8, 16'hA9CB, 4'h0, 1'b0);
        data_in = 16'h1357; load = 1'b1;
        cyc("s3_l2", 16'hA9CB, 4'h0, 1'b0);
        load = 1'b0;
        run("s3_end", 7, 16'hA9CB, 4'h0, 1'b0);
        run("s3_win", 20, 16'h1357, 4'h0, 1'b0);

        // Scenario 4: mask 1010 blanks digits 1 and 3, frame length unchanged.
        run("s4_pre", 19, 16'h1357, 4'h0, 1'b0);
        data_in = 16'h4321; mask_in = 4'b1010; load = 1'b1;
        cyc("s4_ld", 16'h1357, 4'h0, 1'b0);
        load = 1'b0;
        run("s4_mask", 20, 16'h4321, 4'b1010, 1'b0);

        // Scenario 5: pending load, then drop enable in digit 2 SHOW; re-enable restarts.
        run("s5_pre", 10, 16'h4321, 4'b1010, 1'b0);
        data_in = 16'hFEDC; mask_in = 4'h0; load = 1'b1;
        cyc("s5_ld", 16'h4321, 4'b1010, 1'b0);
        load = 1'b0;
        enable = 1'b0;
        cyc("s5_off", 16'h4321, 4'b1010, 1'b0);
        dark("s5_dark0");
        tick();
        dark("s5_dark1");
        tick();
        dark("s5_dark2");
        enable = 1'b1;
        tick();
        pos = 0; first = 1'b1;
        run("s5_re", 24, 16'hFEDC, 4'h0, 1'b0);

        // Scenario 6: asynchronous reset in the GAP after digit 0.
        exp_now("s6_gap", 16'hFEDC, 4'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        dark("s6_async");
        tick();
        dark("s6_held");
        rst_n = 1'b1;
        tick();
        pos = 0; first = 1'b1;
        run("s6_clr", 20, 16'h0000, 4'h0, 1'b0);

        // BLANK=0 variant: 16-cycle frames with no gap cycles.
        rst_b_n = 1'b1;
        data_b  = 16'h4321; mask_b = 4'h0; load_b = 1'b1;
        tick();
        load_b = 1'b0;
        chk("b_idle_sel", {12'h0, sel_b}, 16'h0);
        enable_b = 1'b1;
        tick();
        pos = 0; first = 1'b1;
        run("b0", 33, 16'h4321, 4'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
